// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// buffers one instruction for the decoder. Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
    logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
    logic              misalign_q, misalign_d;
    logic              trap_pend_q, trap_pend_d;

    logic [XLEN-1:0]   redir_target;
    logic              redir_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_target = redirect_pc;
    assign redir_bad    = redirect & (redirect_pc[1:0] != 2'b00);
`else
    // Low bits are discarded: the PC is always word-aligned in this build.
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^redirect_pc[1:0];
    assign redir_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign redir_bad         = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            drop_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            pc_plus4_q    <= '0;
            misalign_q    <= 1'b0;
            trap_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus4_q    <= pc_plus4_d;
            misalign_q    <= misalign_d;
            trap_pend_q   <= trap_pend_d;
        end
    end

    // Next-state and request logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_plus4_d    = pc_plus4_q;
        misalign_d    = misalign_q | redir_bad;
        trap_pend_d   = trap_pend_q;
        imem_req      = 1'b0;
        imem_addr     = pc_q;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = redir_target;
                        if (redir_bad) state_d = S_TRAP;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_plus4_d    = pc_q + XLEN'(4);
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(4);
                        state_d       = S_HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding request must finish at its original address.
                    pc_d        = redir_target;
                    drop_addr_d = pc_q;
                    trap_pend_d = trap_pend_q | redir_bad;
                    state_d     = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redir_target;
                    state_d       = redir_bad ? S_TRAP : S_FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (redirect) begin
                    pc_d        = redir_target;
                    trap_pend_d = trap_pend_q | redir_bad;
                end
                if (imem_ack) begin
                    state_d = (trap_pend_q | redir_bad) ? S_TRAP : S_FETCH;
                end
            end
            S_TRAP: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign pc_plus4     = pc_plus4_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-vector bench for fetch_unit with a scoreboard of accepted instructions.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .pc_plus4     (pc_plus4),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        keep;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] plus4;
    } sb_t;

    localparam int NV = 26;
    vec_t v[NV];
    sb_t  sbq[$];

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                                input logic redir, input logic [31:0] rpc, input logic keep,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid);
        vec_t r;
        r.ack = ack; r.rdata = rdata; r.ready = ready; r.redir = redir; r.rpc = rpc;
        r.keep = keep; r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_mis = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        sb_t e;
        // Basic fetch, delayed ack with stalled decoder
        v[0]  = mk(1, 32'h2008_0005, 1, 0, 0, 1, 1, 32'h0,  0);
        v[1]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 1);
        v[2]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0);
        v[3]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0);
        v[4]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0);
        v[5]  = mk(1, 32'hAAAA_0001, 0, 0, 0, 1, 1, 32'h4, 0);
        v[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        v[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        v[8]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        v[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        v[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        v[11] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 1);
        // Redirect while request to 8 is waiting; its response must be dropped
        v[12] = mk(0, 0, 0, 1, 32'h40, 0, 1, 32'h8, 0);
        v[13] = mk(0, 0, 0, 0, 0, 0, 1, 32'h8, 0);
        v[14] = mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h8, 0);
        v[15] = mk(1, 32'h1111_2222, 0, 0, 0, 1, 1, 32'h40, 0);
        // Redirect in HOLD beats instr_ready
        v[16] = mk(0, 0, 1, 1, 32'h100, 0, 0, 32'h0, 1);
        // Redirect to top of address space, PC wrap
        v[17] = mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h100, 0);
        v[18] = mk(1, 32'hBAD0_0001, 0, 0, 0, 0, 1, 32'h100, 0);
        v[19] = mk(1, 32'h3333_4444, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);
        v[20] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 1);
        // Ack and redirect together in FETCH
        v[21] = mk(1, 32'hBAD0_0002, 0, 1, 32'h200, 0, 1, 32'h0, 0);
        // Misaligned redirect while a request is outstanding
        v[22] = mk(0, 0, 0, 1, 32'h42, 0, 1, 32'h200, 0);
        v[23] = mk(1, 32'hBAD0_0003, 0, 0, 0, 0, 1, 32'h200, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        v[24] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        v[25] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 23; i < NV; i++) v[i].e_mis = 1'b1;
`else
        v[24] = mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0);
        v[25] = mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0);
`endif

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #12;
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            imem_ack    = v[i].ack;
            imem_rdata  = v[i].rdata;
            instr_ready = v[i].ready;
            redirect    = v[i].redir;
            redirect_pc = v[i].rpc;
            #1;
            chk($sformatf("req[%0d]", i), 32'(imem_req), 32'(v[i].e_req));
            if (v[i].e_req) chk($sformatf("addr[%0d]", i), imem_addr, v[i].e_addr);
            chk($sformatf("valid[%0d]", i), 32'(instr_valid), 32'(v[i].e_valid));
            chk($sformatf("misalign[%0d]", i), 32'(misalign_err), 32'(v[i].e_mis));
            if (instr_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty[%0d]: instr %h at pc %h presented, none expected", i, instr, instr_pc);
                end else begin
                    chk($sformatf("sb_instr[%0d]", i), instr, sbq[0].word);
                    chk($sformatf("sb_pc[%0d]", i), instr_pc, sbq[0].pc);
                    chk($sformatf("sb_plus4[%0d]", i), pc_plus4, sbq[0].plus4);
                    if (redirect || instr_ready) void'(sbq.pop_front());
                end
            end
            if (v[i].keep) begin
                e.word  = v[i].rdata;
                e.pc    = v[i].e_addr;
                e.plus4 = v[i].e_addr + 32'd4;
                sbq.push_back(e);
            end
        end

        @(negedge clk);
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        chk("final_valid", 32'(instr_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
